// File: rtl/corefifo_pkg.sv
// Shared helpers for the FWFT prefetch stages: sizing, configuration checks, thresholds.
package corefifo_pkg;

    // Ceiling log2 for sizing counters and pointers (returns 0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Skid buffer must be a power of two so pointers wrap naturally.
    function automatic bit skid_depth_ok(input int unsigned d);
        return (d >= 2) && (d <= 16) && ((d & (d - 1)) == 0);
    endfunction

    // Supported RAM read latencies.
    function automatic bit rd_latency_ok(input int unsigned l);
        return (l >= 1) && (l <= 3);
    endfunction

    // Almost-empty decode: true when the buffer holds thresh words or fewer.
    function automatic logic aempty_hit(input int unsigned cnt, input int unsigned thresh);
        return cnt <= thresh;
    endfunction

endpackage

// File: rtl/corefifo_rdlat_pipe.sv
// Tracks RAM reads in flight: one valid bit per cycle of read latency, plus its popcount.
module corefifo_rdlat_pipe
    import corefifo_pkg::*;
#(
    parameter int unsigned LAT = 1,
    localparam int unsigned INF_W = clog2(LAT + 1)
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             flush,
    input  logic             launch,
    output logic             capture,
    output logic [INF_W-1:0] inflight_c
);

    logic [LAT-1:0] sr;

    // Shift the launch strobe toward the capture position; flush discards all reads.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sr <= '0;
        end else if (flush) begin
            sr <= '0;
        end else begin
            sr[0] <= launch;
            for (int i = 1; i < int'(LAT); i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign capture = sr[LAT-1];

    // Number of reads issued but not yet captured (includes the one capturing now).
    always_comb begin
        inflight_c = '0;
        for (int i = 0; i < int'(LAT); i++) begin
            inflight_c = inflight_c + INF_W'(sr[i]);
        end
    end

endmodule

// File: rtl/corefifo_fwft_skid.sv
// FWFT output stage: credit-tracked prefetch from a latency-N RAM into a register skid buffer.
module corefifo_fwft_skid
    import corefifo_pkg::*;
#(
    parameter int unsigned DWIDTH        = 18,
    parameter int unsigned SKID_DEPTH    = 4,
    parameter int unsigned RD_LATENCY    = 1,
    parameter int unsigned AEMPTY_THRESH = 1,
    localparam int unsigned CNT_W = clog2(SKID_DEPTH + 1),
    localparam int unsigned PTR_W = clog2(SKID_DEPTH)
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              flush,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [DWIDTH-1:0] fifo_dout,
    input  logic              rd_en,
    output logic [DWIDTH-1:0] dout,
    output logic              dvld,
    output logic              empty,
    output logic              aempty,
    output logic [CNT_W-1:0]  count,
    output logic              underflow_err
);

    localparam int unsigned INF_W = clog2(RD_LATENCY + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    // Reject illegal configurations at elaboration.
    if (!skid_depth_ok(SKID_DEPTH)) begin : g_bad_depth
        $error("corefifo_fwft_skid: SKID_DEPTH must be a power of two in 2..16");
    end
    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
        $error("corefifo_fwft_skid: RD_LATENCY must be 1..3");
    end
    if (AEMPTY_THRESH >= SKID_DEPTH) begin : g_bad_thresh
        $error("corefifo_fwft_skid: AEMPTY_THRESH must be below SKID_DEPTH");
    end

    logic [DWIDTH-1:0] mem [SKID_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              capture;
    logic [INF_W-1:0]  inflight_c;
    logic              credit_ok_c;
    logic              cap_c;
    logic              pop_c;

    corefifo_rdlat_pipe #(
        .LAT (RD_LATENCY)
    ) u_rdlat_pipe (
        .clk        (clk),
        .aresetn    (aresetn),
        .flush      (flush),
        .launch     (fifo_rd_en),
        .capture    (capture),
        .inflight_c (inflight_c)
    );

    // Issue a read only when a slot is guaranteed; pops are not credited so the buffer cannot overflow.
    always_comb begin
        credit_ok_c = (SUM_W'(count) + SUM_W'(inflight_c)) < SUM_W'(SKID_DEPTH);
        fifo_rd_en  = !fifo_empty && credit_ok_c && !flush;
        cap_c       = capture && !flush;
        pop_c       = rd_en && !empty && !flush;
    end

    // Skid storage: returning RAM words land at wr_ptr.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < int'(SKID_DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (cap_c) begin
            mem[wr_ptr] <= fifo_dout;
        end
    end

    // Pointers and occupancy; simultaneous capture and pop leave count unchanged.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (cap_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({cap_c, pop_c})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Sticky record of a pop attempted on an empty buffer.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            underflow_err <= 1'b0;
        end else if (flush) begin
            underflow_err <= 1'b0;
        end else if (rd_en && empty) begin
            underflow_err <= 1'b1;
        end
    end

    // Head word and status, all decoded from registered state.
    always_comb begin
        dout   = mem[rd_ptr];
        empty  = (count == '0);
        dvld   = !empty;
        aempty = aempty_hit(32'(count), AEMPTY_THRESH);
    end

endmodule
